chip8_fb_engine: RTL and testbench

//  Parametrised CHIP-8/SCHIP display engine: FB_H x FB_W 1-bit pixel store with command port for
//  XOR sprite-row draw (with collision flag) and full-screen clear, plus an independent video read port.

---
 rtl/chip8_fb_pkg.sv | 26 ++
 rtl/chip8_sprite_mask.sv | 28 ++
 rtl/chip8_fb_engine.sv | 105 ++++++++++
 tb/tb_chip8_fb_engine.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_fb_pkg.sv
// Shared types for the CHIP-8/SCHIP framebuffer engine: command opcodes, FSM states
// and the opcode decode that folds the unused encoding onto NOP.
package chip8_fb_pkg;

    typedef enum logic [1:0] {
        FB_OP_NOP   = 2'd0,
        FB_OP_DRAW  = 2'd1,
        FB_OP_CLEAR = 2'd2
    } fb_op_t;

    typedef enum logic [1:0] {
        FB_IDLE  = 2'd0,
        FB_DRAW  = 2'd1,
        FB_CLEAR = 2'd2,
        FB_DONE  = 2'd3
    } fb_state_t;

    function automatic fb_op_t fb_decode_op(input logic [1:0] op);
        case (op)
            2'd1:    return FB_OP_DRAW;
            2'd2:    return FB_OP_CLEAR;
            default: return FB_OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/chip8_sprite_mask.sv
// Places a sprite row (MSB = leftmost pixel) at column x of an FB_W-wide row mask,
// either wrapping past the right edge or clipping there. Purely combinational.
module chip8_sprite_mask #(
    parameter int FB_W     = 64,
    parameter int ROW_BITS = 8,
    parameter int WRAP     = 1
) (
    input  logic [$clog2(FB_W)-1:0] x,
    input  logic [ROW_BITS-1:0]     data,
    output logic [FB_W-1:0]         mask
);
    localparam int XW = $clog2(FB_W);

    // One extra bit on the column sum: when it is set the pixel landed off-screen.
    logic [XW:0] col;

    always_comb begin
        mask = '0;
        col  = '0;
        for (int i = 0; i < ROW_BITS; i++) begin
            col = {1'b0, x} + (XW+1)'(i);
            if (data[ROW_BITS-1-i] && ((WRAP != 0) || !col[XW])) begin
                mask[col[XW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip8_fb_engine.sv
// CHIP-8/SCHIP display engine: 1-bit FB_H x FB_W pixel store with XOR sprite-row draw,
// collision flag, row-by-row clear, and an independent 1-cycle-latency video read port.
module chip8_fb_engine
    import chip8_fb_pkg::*;
#(
    parameter int FB_W     = 64,
    parameter int FB_H     = 32,
    parameter int ROW_BITS = 8,
    parameter int WRAP     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [$clog2(FB_W)-1:0] cmd_x,
    input  logic [$clog2(FB_H)-1:0] cmd_y,
    input  logic [ROW_BITS-1:0]     cmd_data,
    output logic                    done,
    output logic                    collision,
    input  logic [$clog2(FB_W)-1:0] rd_x,
    input  logic [$clog2(FB_H)-1:0] rd_y,
    output logic                    rd_pixel
);
    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);

    fb_state_t             state;
    logic [XW-1:0]         x_q;
    logic [YW-1:0]         y_q;
    logic [YW-1:0]         row_cnt;
    logic [ROW_BITS-1:0]   data_q;
    logic [FB_W-1:0]       fb_mem [FB_H];
    logic [FB_W-1:0]       mask;
    logic [FB_W-1:0]       cur_row;

    assign cmd_ready = (state == FB_IDLE) && !reset;
    assign cur_row   = fb_mem[y_q];

    chip8_sprite_mask #(
        .FB_W     (FB_W),
        .ROW_BITS (ROW_BITS),
        .WRAP     (WRAP)
    ) u_mask (
        .x    (x_q),
        .data (data_q),
        .mask (mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FB_IDLE;
            done      <= 1'b0;
            collision <= 1'b0;
            rd_pixel  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            data_q    <= '0;
            row_cnt   <= '0;
            for (int r = 0; r < FB_H; r++) begin
                fb_mem[r] <= '0;
            end
        end else begin
            // Nonblocking read sees the row as it was before any write this cycle.
            rd_pixel <= fb_mem[rd_y][rd_x];
            done     <= 1'b0;
            case (state)
                FB_IDLE: begin
                    if (cmd_valid) begin
                        collision <= 1'b0;
                        x_q       <= cmd_x;
                        y_q       <= cmd_y;
                        data_q    <= cmd_data;
                        row_cnt   <= '0;
                        case (fb_decode_op(cmd_op))
                            FB_OP_DRAW:  state <= FB_DRAW;
                            FB_OP_CLEAR: state <= FB_CLEAR;
                            default: begin
                                state <= FB_DONE;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
                FB_DRAW: begin
                    fb_mem[y_q] <= cur_row ^ mask;
                    collision   <= |(cur_row & mask);
                    state       <= FB_DONE;
                    done        <= 1'b1;
                end
                FB_CLEAR: begin
                    fb_mem[row_cnt] <= '0;
                    row_cnt         <= row_cnt + YW'(1);
                    if (row_cnt == YW'(FB_H-1)) begin
                        state <= FB_DONE;
                        done  <= 1'b1;
                    end
                end
                FB_DONE: state <= FB_IDLE;
                default: state <= FB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_fb_engine.sv
// Directed bench: a wrapping and a clipping engine driven in lockstep, checked against
// hand-computed pixels, collision flags and done latencies.
module tb_chip8_fb_engine;
    import chip8_fb_pkg::*;

    localparam int FB_W = 64;
    localparam int FB_H = 32;
    localparam int RB   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [5:0] cmd_x = '0;
    logic [4:0] cmd_y = '0;
    logic [7:0] cmd_data = '0;
    logic [5:0] rd_x = '0;
    logic [4:0] rd_y = '0;
    logic       ready_w, done_w, coll_w, pix_w;
    logic       ready_c, done_c, coll_c, pix_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    chip8_fb_engine #(.FB_W(FB_W), .FB_H(FB_H), .ROW_BITS(RB), .WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_w),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
        .done(done_w), .collision(coll_w), .rd_x(rd_x), .rd_y(rd_y), .rd_pixel(pix_w)
    );

    chip8_fb_engine #(.FB_W(FB_W), .FB_H(FB_H), .ROW_BITS(RB), .WRAP(0)) dut_c (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_c),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
        .done(done_c), .collision(coll_c), .rd_x(rd_x), .rd_y(rd_y), .rd_pixel(pix_c)
    );

    typedef struct packed {
        bit         is_cmd;
        logic [1:0] op;
        int         x;
        int         y;
        logic [7:0] data;
        logic       exp_w;
        logic       exp_c;
        int         exp_lat;
    } vec_t;

    vec_t tv [26];

    function automatic vec_t mk_cmd(input logic [1:0] op, input int x, input int y,
                                    input logic [7:0] d, input logic ew, input logic ec,
                                    input int lat);
        vec_t v;
        v = '{is_cmd: 1'b1, op: op, x: x, y: y, data: d, exp_w: ew, exp_c: ec, exp_lat: lat};
        return v;
    endfunction

    function automatic vec_t mk_rd(input int y, input int x, input logic ew, input logic ec);
        vec_t v;
        v = '{is_cmd: 1'b0, op: 2'd0, x: x, y: y, data: 8'h00, exp_w: ew, exp_c: ec, exp_lat: 0};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic read_px(input int y, input int x, output logic pw, output logic pc);
        @(negedge clk);
        rd_y = 5'(y);
        rd_x = 6'(x);
        @(posedge clk);
        #1;
        pw = pix_w;
        pc = pix_c;
    endtask

    task automatic sweep(output int ones);
        logic pw, pc;
        ones = 0;
        for (int y = 0; y < FB_H; y++) begin
            for (int x = 0; x < FB_W; x++) begin
                read_px(y, x, pw, pc);
                if (pw !== 1'b0) ones++;
                if (pc !== 1'b0) ones++;
            end
        end
    endtask

    // Issues one command; lat is the cycle index (accept cycle = 0) at which done is seen.
    task automatic do_cmd(input logic [1:0] op, input int x, input int y, input logic [7:0] d,
                          output int lat, output logic cw, output logic cc,
                          output int ready_low, output logic dc, output logic done_after);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(ready_w === 1'b1 && ready_c === 1'b1) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = 6'(x);
        cmd_y     = 5'(y);
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        lat       = 1;
        ready_low = 0;
        while (done_w !== 1'b1 && lat < 200) begin
            if (ready_w === 1'b0) ready_low++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (ready_w === 1'b0) ready_low++;
        cw = coll_w;
        cc = coll_c;
        dc = done_c;
        @(posedge clk);
        #1;
        done_after = done_w | done_c;
    endtask

    initial begin
        int   ones, lat, rl, done_seen;
        logic cw, cc, dc, da, pw, pc;

        tv[0]  = mk_cmd(2'd1, 0, 0, 8'hF0, 1'b0, 1'b0, 2);
        tv[1]  = mk_rd(0, 0, 1'b1, 1'b1);
        tv[2]  = mk_rd(0, 3, 1'b1, 1'b1);
        tv[3]  = mk_rd(0, 4, 1'b0, 1'b0);
        tv[4]  = mk_cmd(2'd1, 0, 0, 8'hF0, 1'b1, 1'b1, 2);
        tv[5]  = mk_rd(0, 0, 1'b0, 1'b0);
        tv[6]  = mk_rd(0, 3, 1'b0, 1'b0);
        tv[7]  = mk_cmd(2'd1, 60, 5, 8'hFF, 1'b0, 1'b0, 2);
        tv[8]  = mk_rd(5, 60, 1'b1, 1'b1);
        tv[9]  = mk_rd(5, 63, 1'b1, 1'b1);
        tv[10] = mk_rd(5, 0, 1'b1, 1'b0);
        tv[11] = mk_rd(5, 3, 1'b1, 1'b0);
        tv[12] = mk_rd(5, 4, 1'b0, 1'b0);
        tv[13] = mk_rd(5, 59, 1'b0, 1'b0);
        tv[14] = mk_cmd(2'd1, 0, 5, 8'hF0, 1'b1, 1'b0, 2);
        tv[15] = mk_rd(5, 0, 1'b0, 1'b1);
        tv[16] = mk_cmd(2'd0, 0, 0, 8'h00, 1'b0, 1'b0, 1);
        tv[17] = mk_cmd(2'd3, 0, 0, 8'hFF, 1'b0, 1'b0, 1);
        tv[18] = mk_cmd(2'd1, 62, 31, 8'hA5, 1'b0, 1'b0, 2);
        tv[19] = mk_rd(31, 62, 1'b1, 1'b1);
        tv[20] = mk_rd(31, 63, 1'b0, 1'b0);
        tv[21] = mk_rd(31, 0, 1'b1, 1'b0);
        tv[22] = mk_rd(31, 3, 1'b1, 1'b0);
        tv[23] = mk_rd(31, 5, 1'b1, 1'b0);
        tv[24] = mk_rd(31, 4, 1'b0, 1'b0);
        tv[25] = mk_cmd(2'd1, 62, 31, 8'hA5, 1'b1, 1'b1, 2);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_w", ready_w, 0);
        check("rst_done_w", done_w, 0);
        check("rst_coll_w", coll_w, 0);
        check("rst_pix_w", pix_w, 0);
        check("rst_done_c", done_c, 0);
        check("rst_coll_c", coll_c, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst_w", ready_w, 1);
        check("ready_after_rst_c", ready_c, 1);
        sweep(ones);
        check("rst_sweep_ones", ones, 0);

        for (int i = 0; i < 26; i++) begin
            if (tv[i].is_cmd) begin
                do_cmd(tv[i].op, tv[i].x, tv[i].y, tv[i].data, lat, cw, cc, rl, dc, da);
                check($sformatf("v%0d_lat", i), lat, tv[i].exp_lat);
                check($sformatf("v%0d_done_c", i), dc, 1);
                check($sformatf("v%0d_coll_wrap", i), cw, tv[i].exp_w);
                check($sformatf("v%0d_coll_clip", i), cc, tv[i].exp_c);
            end else begin
                read_px(tv[i].y, tv[i].x, pw, pc);
                check($sformatf("v%0d_pix_wrap", i), pw, tv[i].exp_w);
                check($sformatf("v%0d_pix_clip", i), pc, tv[i].exp_c);
            end
        end

        // Fill every row, leave collision high, then full clear
        for (int y = 0; y < FB_H; y++) begin
            do_cmd(2'd1, (y * 8) % FB_W, y, 8'hFF, lat, cw, cc, rl, dc, da);
        end
        read_px(7, 56, pw, pc);
        check("fill_pix_w", pw, 1);
        check("fill_pix_c", pc, 1);
        do_cmd(2'd1, 0, 0, 8'h01, lat, cw, cc, rl, dc, da);
        check("pre_clr_coll", cw, 1);
        do_cmd(2'd2, 0, 0, 8'h00, lat, cw, cc, rl, dc, da);
        check("clr_lat", lat, FB_H + 1);
        check("clr_ready_low", rl, FB_H + 1);
        check("clr_done_c", dc, 1);
        check("clr_single_done", da, 0);
        check("clr_coll_w", cw, 0);
        check("clr_coll_c", cc, 0);
        sweep(ones);
        check("clr_sweep_ones", ones, 0);

        // Reset while the clear is on row 10: rows beyond it only reset can zero
        for (int y = 20; y < FB_H; y++) begin
            do_cmd(2'd1, 0, y, 8'hFF, lat, cw, cc, rl, dc, da);
        end
        do_cmd(2'd1, 8, 3, 8'hFF, lat, cw, cc, rl, dc, da);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        done_seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done_w !== 1'b0 || done_c !== 1'b0) done_seen++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        if (done_w !== 1'b0 || done_c !== 1'b0) done_seen++;
        reset = 1'b0;
        #1;
        check("abort_idle_w", ready_w, 1);
        check("abort_idle_c", ready_c, 1);
        check("abort_coll_w", coll_w, 0);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_w !== 1'b0 || done_c !== 1'b0) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        sweep(ones);
        check("abort_sweep_ones", ones, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
